// File: rtl/fir_in_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_in_fifo_if
// Description : Sample-path bundle between the sample source, the input FIFO
//               and the FIR filter.
//               slave  = the FIFO side; master = the source/observer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_in_fifo_if #(
  parameter int NB = 12,
  parameter int AW = 4
);
  logic signed [NB-1:0] DIN;
  logic                 VIN;
  logic                 EN;
  logic                 FLUSH;
  logic signed [NB-1:0] DOUT;
  logic                 VOUT;
  logic                 FULL;
  logic                 EMPTY;
  logic                 OVF;
  logic [AW:0]          LEVEL;

  modport slave (
    input  DIN, VIN, EN, FLUSH,
    output DOUT, VOUT, FULL, EMPTY, OVF, LEVEL
  );

  modport master (
    output DIN, VIN, EN, FLUSH,
    input  DOUT, VOUT, FULL, EMPTY, OVF, LEVEL
  );
endinterface
`default_nettype wire

// File: rtl/fir_in_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_in_fifo
// Description : Circular input buffer feeding the FIR filter. Absorbs bursty
//               source samples and issues one registered sample per cycle
//               while EN is high. Reports FULL/EMPTY/LEVEL and a sticky OVF.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_in_fifo #(
  parameter int NB    = 12,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  fir_in_fifo_if.slave bus
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable
  // without a separate counter; wrap is plain binary overflow.
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [NB-1:0] r_mem [DEPTH];
  logic [NB-1:0] r_dout;
  logic          r_vout;
  logic          r_ovf;

  logic [AW:0]   w_level;
  logic          w_full;
  logic          w_empty;
  logic          w_rd;
  logic          w_wr;
  logic          w_drop;

  assign w_level = r_wptr - r_rptr;
  assign w_full  = (w_level == C_DEPTH);
  assign w_empty = (w_level == '0);

  // A read frees a slot in the same edge, so a full buffer still accepts
  // a write when it is also issuing.
  assign w_rd   = bus.EN & ~w_empty & ~bus.FLUSH;
  assign w_wr   = bus.VIN & ~bus.FLUSH & (~w_full | w_rd);
  assign w_drop = bus.VIN & w_full & ~w_rd & ~bus.FLUSH;

  // Pointer, output register and overflow flag update; FLUSH outranks all
  // but reset and leaves DOUT holding its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_dout <= '0;
      r_vout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (bus.FLUSH) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_vout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_vout <= w_rd;
      if (w_rd) begin
        r_dout <= r_mem[r_rptr[AW-1:0]];
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Sample storage; deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= bus.DIN;
    end
  end

  assign bus.DOUT  = r_dout;
  assign bus.VOUT  = r_vout;
  assign bus.OVF   = r_ovf;
  assign bus.FULL  = w_full;
  assign bus.EMPTY = w_empty;
  assign bus.LEVEL = w_level;

endmodule
`default_nettype wire
